axi_burst_terminator: RTL and testbench

//  Parametrised AXI4 slave sink: accepts every write/read burst on an otherwise unused master port and completes it

---
 rtl/axi_burst_terminator.sv | 231 +++++++++++++++++++++++
 tb/tb_axi_burst_terminator.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_terminator.sv
// rtl/axi_burst_terminator.sv - AXI4 slave sink that completes every burst on an unused master port.
// Independent write and read FSMs (one outstanding burst each), ID echo, completion counters.
module axi_burst_terminator #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter int          ID_WIDTH   = 4,
  parameter logic [1:0]  WRITE_RESP = 2'b00,
  parameter logic [1:0]  READ_RESP  = 2'b00,
  parameter int          READ_MODE  = 0,
  parameter logic [31:0] READ_FILL  = 32'hDEADBEEF,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ID_WIDTH-1:0]     awid_i,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic [7:0]              awlen_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wlast_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [ID_WIDTH-1:0]     bid_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  input  logic [ID_WIDTH-1:0]     arid_i,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic [7:0]              arlen_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  output logic [ID_WIDTH-1:0]     rid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rlast_o,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  input  logic                    clear_counters_i,
  output logic [CNT_WIDTH-1:0]    wr_count_o,
  output logic [CNT_WIDTH-1:0]    rd_count_o,
  output logic                    burst_error_o
);
  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  w_state_e              w_state_q;
  r_state_e              r_state_q;
  logic [7:0]            w_len_q, w_beat_q, r_len_q, r_beat_q;
  logic [ID_WIDTH-1:0]   w_id_q, r_id_q;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic                  awready_q, wready_q, bvalid_q, arready_q, rvalid_q, rlast_q;
  logic [ID_WIDTH-1:0]   bid_q, rid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic                  berr_q, berr_d;

  logic                  w_beat_hs, w_is_last, w_err_set, wr_done, rd_done;
  logic [ADDR_WIDTH-1:0] r_addr_next;
  logic                  unused_inputs;

  assign unused_inputs = ^{awaddr_i, wdata_i, wstrb_i};

  function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    if (READ_MODE == 1) begin
      for (int i = 0; i < DATA_WIDTH && i < ADDR_WIDTH; i++) d[i] = a[i];
    end else begin
      for (int i = 0; i < DATA_WIDTH && i < 32; i++) d[i] = READ_FILL[i];
    end
    return d;
  endfunction

  assign w_beat_hs   = (w_state_q == W_DATA) && wvalid_i && wready_q;
  assign w_is_last   = wlast_i || (w_beat_q == w_len_q);
  assign w_err_set   = w_beat_hs && (wlast_i != (w_beat_q == w_len_q));
  assign wr_done     = (w_state_q == W_RESP) && bvalid_q && bready_i;
  assign rd_done     = (r_state_q == R_DATA) && rvalid_q && rready_i && rlast_q;
  assign r_addr_next = r_addr_q + ADDR_WIDTH'(BYTES);

  // Write FSM: W is held off (wready=0) until AW has been accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_id_q    <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (awvalid_i && awready_q) begin
            w_id_q    <= awid_i;
            w_len_q   <= awlen_i;
            w_beat_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state_q <= W_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_beat_hs) begin
            if (w_is_last) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bid_q     <= w_id_q;
              bresp_q   <= WRITE_RESP;
              w_state_q <= W_RESP;
            end else begin
              w_beat_q <= w_beat_q + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (bready_i) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q <= R_IDLE;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (arvalid_i && arready_q) begin
            r_id_q    <= arid_i;
            r_len_q   <= arlen_i;
            r_addr_q  <= araddr_i;
            r_beat_q  <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rid_q     <= arid_i;
            rresp_q   <= READ_RESP;
            rdata_q   <= beat_data(araddr_i);
            rlast_q   <= (arlen_i == 8'd0);
            r_state_q <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready_i) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              r_beat_q <= r_beat_q + 8'd1;
              r_addr_q <= r_addr_next;
              rdata_q  <= beat_data(r_addr_next);
              rlast_q  <= ((r_beat_q + 8'd1) == r_len_q);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Clear takes priority over a coincident completion or error.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    berr_d   = berr_q | w_err_set;
    if (clear_counters_i) begin
      wr_cnt_d = '0;
      rd_cnt_d = '0;
      berr_d   = 1'b0;
    end else begin
      if (wr_done && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 1'b1;
      if (rd_done && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      berr_q   <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      berr_q   <= berr_d;
    end
  end

  assign awready_o     = awready_q;
  assign wready_o      = wready_q;
  assign bvalid_o      = bvalid_q;
  assign bid_o         = bid_q;
  assign bresp_o       = bresp_q;
  assign arready_o     = arready_q;
  assign rvalid_o      = rvalid_q;
  assign rlast_o       = rlast_q;
  assign rid_o         = rid_q;
  assign rresp_o       = rresp_q;
  assign rdata_o       = rdata_q;
  assign wr_count_o    = wr_cnt_q;
  assign rd_count_o    = rd_cnt_q;
  assign burst_error_o = berr_q;

endmodule

// File: tb/tb_axi_burst_terminator.sv
// tb/tb_axi_burst_terminator.sv - directed self-checking bench for axi_burst_terminator.
module tb_axi_burst_terminator;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awid, arid;
  logic [31:0] awaddr, araddr, wdata;
  logic [7:0]  awlen, arlen;
  logic [3:0]  wstrb;
  logic        awvalid, wlast, wvalid, bready, arvalid, rready, clear;

  logic        awready, wready, bvalid, arready, rvalid, rlast, berr;
  logic [3:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [1:0]  wr_cnt, rd_cnt;

  logic        f_awready, f_wready, f_bvalid, f_arready, f_rvalid, f_rlast, f_berr;
  logic [3:0]  f_bid, f_rid;
  logic [1:0]  f_bresp, f_rresp;
  logic [31:0] f_rdata;
  logic [1:0]  f_wr_cnt, f_rd_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_burst_terminator #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .WRITE_RESP(2'b10), .READ_RESP(2'b11),
    .READ_MODE(1), .READ_FILL(32'hDEADBEEF), .CNT_WIDTH(2)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
    .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arvalid_i(arvalid), .arready_o(arready),
    .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid), .rready_i(rready),
    .clear_counters_i(clear), .wr_count_o(wr_cnt), .rd_count_o(rd_cnt), .burst_error_o(berr)
  );

  axi_burst_terminator #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .WRITE_RESP(2'b10), .READ_RESP(2'b11),
    .READ_MODE(0), .READ_FILL(32'hDEADBEEF), .CNT_WIDTH(2)
  ) u_fill (
    .clk_i(clk), .rst_ni(rst_n),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awvalid_i(awvalid), .awready_o(f_awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(f_wready),
    .bid_o(f_bid), .bresp_o(f_bresp), .bvalid_o(f_bvalid), .bready_i(bready),
    .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arvalid_i(arvalid), .arready_o(f_arready),
    .rid_o(f_rid), .rdata_o(f_rdata), .rresp_o(f_rresp), .rlast_o(f_rlast), .rvalid_o(f_rvalid), .rready_i(rready),
    .clear_counters_i(clear), .wr_count_o(f_wr_cnt), .rd_count_o(f_rd_cnt), .burst_error_o(f_berr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // AW+AR single-beat pair whose B and R complete on the same edge.
  task automatic do_pair(input logic clr);
    awvalid = 1'b1; awid = 4'h1; awlen = 8'd0;
    arvalid = 1'b1; arid = 4'h2; araddr = 32'h40; arlen = 8'd0;
    step();
    awvalid = 1'b0; arvalid = 1'b0;
    wvalid = 1'b1; wlast = 1'b1;
    step();
    wvalid = 1'b0; wlast = 1'b0;
    check("pair_bvalid", bvalid, 1'b1);
    check("pair_rvalid", rvalid, 1'b1);
    bready = 1'b1; rready = 1'b1; clear = clr;
    step();
    bready = 1'b0; rready = 1'b0; clear = 1'b0;
  endtask

  initial begin
    int b, acc, cyc;
    logic hs;
    rst_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = 32'h1234_5678; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0; clear = 1'b0;
    repeat (3) step();
    check("rst_awready", awready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_wr_cnt", wr_cnt, 2'd0);
    check("rst_berr", berr, 1'b0);
    rst_n = 1'b1;
    step();
    check("idle_awready", awready, 1'b1);
    check("idle_arready", arready, 1'b1);
    check("idle_wready", wready, 1'b0);

    // single-beat write
    awvalid = 1'b1; awid = 4'd3; awlen = 8'd0;
    step();
    awvalid = 1'b0;
    check("t1_wready", wready, 1'b1);
    check("t1_awready_low", awready, 1'b0);
    wvalid = 1'b1; wlast = 1'b1;
    step();
    wvalid = 1'b0; wlast = 1'b0;
    check("t1_bvalid", bvalid, 1'b1);
    check("t1_bid", bid, 4'd3);
    check("t1_bresp", bresp, 2'b10);
    check("t1_wready_low", wready, 1'b0);
    bready = 1'b1;
    step();
    bready = 1'b0;
    check("t1_bvalid_drop", bvalid, 1'b0);
    check("t1_wr_cnt", wr_cnt, 2'd1);
    check("t1_awready_back", awready, 1'b1);
    check("t1_berr", berr, 1'b0);

    // 4-beat read, address-pattern data
    arvalid = 1'b1; arid = 4'd5; araddr = 32'h100; arlen = 8'd3;
    step();
    arvalid = 1'b0;
    check("t2_arready_low", arready, 1'b0);
    check("t2_rid", rid, 4'd5);
    check("t2_rresp", rresp, 2'b11);
    rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_rvalid", rvalid, 1'b1);
      check("t2_rdata", rdata, 32'h100 + 32'(4 * i));
      check("t2_rlast", rlast, (i == 3));
      check("t2_fill", f_rdata, 32'hDEADBEEF);
      step();
    end
    rready = 1'b0;
    check("t2_rvalid_drop", rvalid, 1'b0);
    check("t2_rd_cnt", rd_cnt, 2'd1);
    check("t2_arready_back", arready, 1'b1);

    // early wlast on an 8-beat burst
    awvalid = 1'b1; awid = 4'd9; awlen = 8'd7;
    step();
    awvalid = 1'b0;
    wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wlast = (i == 3);
      step();
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("t3_bvalid", bvalid, 1'b1);
    check("t3_bid", bid, 4'd9);
    check("t3_berr", berr, 1'b1);
    bready = 1'b1;
    step();
    bready = 1'b0;
    check("t3_wr_cnt", wr_cnt, 2'd2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t3_berr_clr", berr, 1'b0);
    check("t3_wr_clr", wr_cnt, 2'd0);
    check("t3_rd_clr", rd_cnt, 2'd0);

    // missing wlast: burst ends at awlen
    awvalid = 1'b1; awid = 4'd4; awlen = 8'd1;
    step();
    awvalid = 1'b0;
    wvalid = 1'b1; wlast = 1'b0;
    step();
    check("t3b_no_err_yet", berr, 1'b0);
    check("t3b_no_b_yet", bvalid, 1'b0);
    step();
    wvalid = 1'b0;
    check("t3b_bvalid", bvalid, 1'b1);
    check("t3b_berr", berr, 1'b1);
    bready = 1'b1;
    step();
    bready = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t3b_clr", berr, 1'b0);

    // 16-beat read with random rready stalls
    arvalid = 1'b1; arid = 4'd7; araddr = 32'h200; arlen = 8'd15;
    step();
    arvalid = 1'b0;
    b = 0; cyc = 0;
    while (b < 16 && cyc < 200) begin
      rready = 1'($urandom_range(0, 1));
      if (rvalid) begin
        check("t4_rdata", rdata, 32'h200 + 32'(4 * b));
        check("t4_rid", rid, 4'd7);
        check("t4_rlast", rlast, (b == 15));
      end
      hs = rvalid && rready;
      step();
      if (hs) b++;
      cyc++;
    end
    rready = 1'b0;
    check("t4_rd_beats", b, 16);
    check("t4_rvalid_end", rvalid, 1'b0);
    check("t4_rd_cnt", rd_cnt, 2'd1);

    // 16-beat write with random wvalid, then stalled B
    awvalid = 1'b1; awid = 4'hA; awlen = 8'd15;
    step();
    awvalid = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 16 && cyc < 200) begin
      wvalid = 1'($urandom_range(0, 1));
      wlast = (acc == 15);
      hs = wvalid && wready;
      if (acc < 16) check("t4_no_early_b", bvalid, 1'b0);
      step();
      if (hs) acc++;
      cyc++;
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("t4_wr_beats", acc, 16);
    for (int i = 0; i < 3; i++) begin
      check("t4_b_held", bvalid, 1'b1);
      check("t4_bid_held", bid, 4'hA);
      step();
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    check("t4_wr_cnt", wr_cnt, 2'd1);
    check("t4_berr", berr, 1'b0);

    // coincident completions, saturation, clear priority
    do_pair(1'b0);
    check("t5_wr_2", wr_cnt, 2'd2);
    check("t5_rd_2", rd_cnt, 2'd2);
    do_pair(1'b0);
    check("t5_wr_3", wr_cnt, 2'd3);
    check("t5_rd_3", rd_cnt, 2'd3);
    do_pair(1'b0);
    check("t5_wr_sat", wr_cnt, 2'd3);
    check("t5_rd_sat", rd_cnt, 2'd3);
    do_pair(1'b1);
    check("t5_wr_clr_wins", wr_cnt, 2'd0);
    check("t5_rd_clr_wins", rd_cnt, 2'd0);

    // reset in the middle of an 8-beat read
    arvalid = 1'b1; arid = 4'd6; araddr = 32'h300; arlen = 8'd7;
    step();
    arvalid = 1'b0;
    rready = 1'b1;
    step();
    step();
    check("t6_beat2", rdata, 32'h308);
    rready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_rvalid_async", rvalid, 1'b0);
    check("t6_arready_rst", arready, 1'b0);
    check("t6_rid_rst", rid, 4'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("t6_arready", arready, 1'b1);
    check("t6_rvalid_idle", rvalid, 1'b0);
    check("t6_rd_cnt", rd_cnt, 2'd0);
    arvalid = 1'b1; arid = 4'd2; araddr = 32'h10; arlen = 8'd1;
    step();
    arvalid = 1'b0;
    check("t6_new_rdata", rdata, 32'h10);
    check("t6_new_rid", rid, 4'd2);
    rready = 1'b1;
    step();
    check("t6_new_rlast", rlast, 1'b1);
    check("t6_new_rdata2", rdata, 32'h14);
    step();
    rready = 1'b0;
    check("t6_new_done", rvalid, 1'b0);
    check("t6_new_cnt", rd_cnt, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
